// File: rtl/sha1_arbiter_pkg.sv
// Shared types and widths for the sha1 arbiter/sequencer and its round-robin grant logic.
// Covers the sequencer states, block/digest/round-index widths and pointer arithmetic.
package sha1_arbiter_pkg;

    localparam int BLOCK_W   = 512;
    localparam int DIGEST_W  = 160;
    localparam int IDX_W     = 7;
    localparam int REQ_IDX_W = 2;
    localparam int MAX_REQ   = 4;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_LOAD = 2'd1,
        ST_RUN  = 2'd2,
        ST_RESP = 2'd3
    } arb_state_e;

    // Next round-robin position: one past the last grantee, wrapping at n.
    function automatic logic [REQ_IDX_W-1:0] rr_next(input logic [REQ_IDX_W-1:0] idx,
                                                     input int n);
        if (idx == REQ_IDX_W'(n - 1)) begin
            rr_next = '0;
        end else begin
            rr_next = idx + REQ_IDX_W'(1);
        end
    endfunction

endpackage

// File: rtl/sha1_arbiter_rr_arbiter.sv
// Combinational round-robin grant: picks the first valid requester at or after ptr_i,
// wrapping around. Purely combinational so any shared engine can add its own state.
module rr_arbiter
    import sha1_arbiter_pkg::*;
#(
    parameter int NUM_REQ = 2
) (
    input  logic [NUM_REQ-1:0]   valid_i,
    input  logic [REQ_IDX_W-1:0] ptr_i,
    output logic [NUM_REQ-1:0]   grant_o,
    output logic [REQ_IDX_W-1:0] grant_idx_o,
    output logic                 any_o
);

    always_comb begin
        grant_o     = '0;
        grant_idx_o = '0;
        any_o       = 1'b0;
        // First pass covers ptr..NUM_REQ-1, second pass wraps to 0..ptr-1.
        for (int i = 0; i < NUM_REQ; i++) begin
            if (!any_o && valid_i[i] && (i >= int'(ptr_i))) begin
                any_o       = 1'b1;
                grant_o[i]  = 1'b1;
                grant_idx_o = REQ_IDX_W'(i);
            end
        end
        for (int i = 0; i < NUM_REQ; i++) begin
            if (!any_o && valid_i[i]) begin
                any_o       = 1'b1;
                grant_o[i]  = 1'b1;
                grant_idx_o = REQ_IDX_W'(i);
            end
        end
    end

endmodule

// File: rtl/sha1_arbiter.sv
// Shares one sha1 core between NUM_REQ requesters: grants a block round-robin, resets and
// runs the core, and returns the digest (or a timeout error) to the requester that won.
module sha1_arbiter
    import sha1_arbiter_pkg::*;
#(
    parameter int NUM_REQ        = 2,
    parameter int TIMEOUT_CYCLES = 255
) (
    input  logic                         wb_clk_i,
    input  logic                         reset,
    input  logic [NUM_REQ-1:0]           req_valid,
    output logic [NUM_REQ-1:0]           req_ready,
    input  logic [NUM_REQ*BLOCK_W-1:0]   req_msg,
    output logic [NUM_REQ-1:0]           rsp_valid,
    input  logic [NUM_REQ-1:0]           rsp_ready,
    output logic [DIGEST_W-1:0]          rsp_digest,
    output logic                         rsp_error,
    output logic                         core_reset,
    output logic                         core_on,
    output logic [BLOCK_W-1:0]           core_msg,
    input  logic [DIGEST_W-1:0]          core_digest,
    input  logic                         core_finish,
    input  logic [IDX_W-1:0]             core_idx,
    output logic                         busy,
    output logic [REQ_IDX_W-1:0]         owner,
    output logic [IDX_W-1:0]             loop_idx
);

    localparam int              TO_W    = $clog2(TIMEOUT_CYCLES + 1);
    localparam logic [TO_W-1:0] TO_LAST = TO_W'(TIMEOUT_CYCLES - 1);

    arb_state_e             state_q, state_d;
    logic [REQ_IDX_W-1:0]   owner_q, owner_d;
    logic [REQ_IDX_W-1:0]   ptr_q, ptr_d;
    logic [BLOCK_W-1:0]     msg_q, msg_d;
    logic [DIGEST_W-1:0]    digest_q, digest_d;
    logic                   error_q, error_d;
    logic [TO_W-1:0]        cnt_q, cnt_d;
    logic                   busy_q;

    logic [NUM_REQ-1:0]     grant;
    logic [REQ_IDX_W-1:0]   grant_idx;
    logic                   grant_any;
    logic [BLOCK_W-1:0]     msg_sel;
    logic [NUM_REQ-1:0]     owner_oh;
    logic                   rsp_hs;

    rr_arbiter #(
        .NUM_REQ (NUM_REQ)
    ) u_rr (
        .valid_i     (req_valid),
        .ptr_i       (ptr_q),
        .grant_o     (grant),
        .grant_idx_o (grant_idx),
        .any_o       (grant_any)
    );

    always_comb begin
        msg_sel = '0;
        for (int i = 0; i < NUM_REQ; i++) begin
            if (grant[i]) begin
                msg_sel = req_msg[i*BLOCK_W +: BLOCK_W];
            end
        end
    end

    always_comb begin
        owner_oh = '0;
        for (int i = 0; i < NUM_REQ; i++) begin
            owner_oh[i] = (owner_q == REQ_IDX_W'(i));
        end
    end

    // Non-owner rsp_ready bits are masked out here.
    assign rsp_hs = |(owner_oh & rsp_ready);

    always_comb begin
        state_d    = state_q;
        owner_d    = owner_q;
        ptr_d      = ptr_q;
        msg_d      = msg_q;
        digest_d   = digest_q;
        error_d    = error_q;
        cnt_d      = cnt_q;
        req_ready  = '0;
        rsp_valid  = '0;
        core_reset = 1'b1;
        core_on    = 1'b0;

        unique case (state_q)
            ST_IDLE: begin
                if (!reset) begin
                    req_ready = grant;
                end
                if (grant_any) begin
                    msg_d   = msg_sel;
                    owner_d = grant_idx;
                    ptr_d   = rr_next(grant_idx, NUM_REQ);
                    state_d = ST_LOAD;
                end
            end
            ST_LOAD: begin
                cnt_d   = '0;
                state_d = ST_RUN;
            end
            ST_RUN: begin
                core_reset = 1'b0;
                core_on    = 1'b1;
                // A finish on the last allowed cycle still counts as success.
                if (core_finish) begin
                    digest_d = core_digest;
                    error_d  = 1'b0;
                    state_d  = ST_RESP;
                end else if (cnt_q == TO_LAST) begin
                    digest_d = '0;
                    error_d  = 1'b1;
                    state_d  = ST_RESP;
                end else begin
                    cnt_d = cnt_q + TO_W'(1);
                end
            end
            ST_RESP: begin
                rsp_valid = owner_oh;
                if (rsp_hs) begin
                    state_d = ST_IDLE;
                end
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase

        // Reset takes effect on the core pins immediately, ahead of the synchronous state reset.
        if (reset) begin
            core_reset = 1'b1;
            core_on    = 1'b0;
            rsp_valid  = '0;
        end
    end

    always_ff @(posedge wb_clk_i) begin
        if (reset) begin
            state_q  <= ST_IDLE;
            owner_q  <= '0;
            ptr_q    <= '0;
            msg_q    <= '0;
            digest_q <= '0;
            error_q  <= 1'b0;
            cnt_q    <= '0;
            busy_q   <= 1'b0;
        end else begin
            state_q  <= state_d;
            owner_q  <= owner_d;
            ptr_q    <= ptr_d;
            msg_q    <= msg_d;
            digest_q <= digest_d;
            error_q  <= error_d;
            cnt_q    <= cnt_d;
            busy_q   <= (state_d != ST_IDLE);
        end
    end

    assign core_msg   = msg_q;
    assign rsp_digest = digest_q;
    assign rsp_error  = error_q;
    assign owner      = owner_q;
    assign busy       = busy_q;
    assign loop_idx   = core_idx;

endmodule

// File: tb/tb_sha1_arbiter.sv
// Directed bench for sha1_arbiter: a behavioural sha1 core behind one instance, and a
// never-finishing stub (TIMEOUT_CYCLES=16) behind a second instance.
module tb_sha1_arbiter;

    localparam int NR = 2;

    localparam logic [511:0] M_ABC = {32'h61626380, 448'h0, 32'h00000018};
    localparam logic [511:0] M_A   = {32'h61800000, 448'h0, 32'h00000008};
    localparam logic [511:0] M_E   = {32'h80000000, 480'h0};
    localparam logic [159:0] D_ABC = 160'ha9993e36_4706816a_ba3e2571_7850c26c_9cd0d89d;
    localparam logic [159:0] D_A   = 160'h86f7e437_faa5a7fc_e15d1ddc_b9eaeaea_377667b8;
    localparam logic [159:0] D_E   = 160'hda39a3ee_5e6b4b0d_3255bfef_95601890_afd80709;
    localparam logic [159:0] D_STUB = 160'h01234567_89abcdef_00112233_44556677_8899aabb;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic             reset;
    logic [NR-1:0]    req_valid, req_ready, rsp_valid, rsp_ready;
    logic [NR*512-1:0] req_msg;
    logic [159:0]     rsp_digest, core_digest;
    logic             rsp_error, core_reset, core_on, core_finish, busy;
    logic [511:0]     core_msg;
    logic [6:0]       core_idx, loop_idx;
    logic [1:0]       owner;

    logic [NR-1:0]    t_req_valid, t_req_ready, t_rsp_valid, t_rsp_ready;
    logic [NR*512-1:0] t_req_msg;
    logic [159:0]     t_rsp_digest, t_core_digest;
    logic             t_rsp_error, t_core_reset, t_core_on, t_core_finish, t_busy;
    logic [511:0]     t_core_msg;
    logic [6:0]       t_core_idx, t_loop_idx;
    logic [1:0]       t_owner;

    sha1_arbiter #(.NUM_REQ(NR), .TIMEOUT_CYCLES(255)) dut (
        .wb_clk_i(clk), .reset(reset),
        .req_valid(req_valid), .req_ready(req_ready), .req_msg(req_msg),
        .rsp_valid(rsp_valid), .rsp_ready(rsp_ready),
        .rsp_digest(rsp_digest), .rsp_error(rsp_error),
        .core_reset(core_reset), .core_on(core_on), .core_msg(core_msg),
        .core_digest(core_digest), .core_finish(core_finish), .core_idx(core_idx),
        .busy(busy), .owner(owner), .loop_idx(loop_idx)
    );

    sha1_arbiter #(.NUM_REQ(NR), .TIMEOUT_CYCLES(16)) dut_to (
        .wb_clk_i(clk), .reset(reset),
        .req_valid(t_req_valid), .req_ready(t_req_ready), .req_msg(t_req_msg),
        .rsp_valid(t_rsp_valid), .rsp_ready(t_rsp_ready),
        .rsp_digest(t_rsp_digest), .rsp_error(t_rsp_error),
        .core_reset(t_core_reset), .core_on(t_core_on), .core_msg(t_core_msg),
        .core_digest(t_core_digest), .core_finish(t_core_finish), .core_idx(t_core_idx),
        .busy(t_busy), .owner(t_owner), .loop_idx(t_loop_idx)
    );

    // Reference SHA-1 compression of one padded block from the standard IV.
    function automatic logic [159:0] sha1_blk(input logic [511:0] m);
        logic [31:0] w [80];
        logic [31:0] a, b, c, d, e, f, k, tmp;
        for (int t = 0; t < 16; t++) w[t] = m[511 - 32*t -: 32];
        for (int t = 16; t < 80; t++) begin
            tmp  = w[t-3] ^ w[t-8] ^ w[t-14] ^ w[t-16];
            w[t] = {tmp[30:0], tmp[31]};
        end
        a = 32'h67452301; b = 32'hEFCDAB89; c = 32'h98BADCFE;
        d = 32'h10325476; e = 32'hC3D2E1F0;
        for (int t = 0; t < 80; t++) begin
            if (t < 20)      begin f = (b & c) | (~b & d);         k = 32'h5A827999; end
            else if (t < 40) begin f = b ^ c ^ d;                  k = 32'h6ED9EBA1; end
            else if (t < 60) begin f = (b & c) | (b & d) | (c & d); k = 32'h8F1BBCDC; end
            else             begin f = b ^ c ^ d;                  k = 32'hCA62C1D6; end
            tmp = {a[26:0], a[31:27]} + f + e + k + w[t];
            e = d; d = c; c = {b[1:0], b[31:2]}; b = a; a = tmp;
        end
        return {a + 32'h67452301, b + 32'hEFCDAB89, c + 32'h98BADCFE,
                d + 32'h10325476, e + 32'hC3D2E1F0};
    endfunction

    // Core model: 80 rounds after reset release, then finish held as a level.
    logic [6:0] cm_cnt;
    always @(posedge clk) begin
        if (core_reset) begin
            cm_cnt      <= 7'd0;
            core_finish <= 1'b0;
            core_digest <= '0;
        end else if (core_on && !core_finish) begin
            if (cm_cnt == 7'd79) begin
                core_finish <= 1'b1;
                core_digest <= sha1_blk(core_msg);
            end
            cm_cnt <= cm_cnt + 7'd1;
        end
    end
    assign core_idx = cm_cnt;

    int n_vec = 0;
    int n_bad = 0;

    task automatic chk(input string name, input logic [511:0] act, input logic [511:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    function automatic logic [1:0] oh(input logic [1:0] i);
        return 2'b01 << i;
    endfunction

    task automatic wait_rsp(output int lat);
        lat = 0;
        for (int c = 0; c < 400; c++) begin
            if (|rsp_valid) return;
            @(posedge clk);
            lat++;
            @(negedge clk);
        end
        lat = -1;
    endtask

    typedef struct {
        logic [1:0]   valid;
        logic [511:0] m0;
        logic [511:0] m1;
        logic [1:0]   own;
        logic [159:0] dig;
    } vec_t;

    // Called at a negedge while the arbiter is IDLE.
    task automatic run_vec(input vec_t v, input string tag);
        int lat;
        bit got;
        req_valid = v.valid;
        req_msg   = {v.m1, v.m0};
        #1;
        got = 0;
        for (int c = 0; c < 8; c++) begin
            if (|req_ready) begin got = 1; break; end
            @(negedge clk); #1;
        end
        chk({tag, ".grant"}, req_ready, oh(v.own));
        @(posedge clk);
        @(negedge clk);
        req_valid = req_valid & ~oh(v.own);
        chk({tag, ".busy_load"}, busy, 1'b1);
        chk({tag, ".core_msg"}, core_msg, (v.own == 2'd0) ? v.m0 : v.m1);
        wait_rsp(lat);
        chk({tag, ".latency"}, lat, 82);
        chk({tag, ".rsp_valid"}, rsp_valid, oh(v.own));
        chk({tag, ".owner"}, owner, v.own);
        chk({tag, ".digest"}, rsp_digest, v.dig);
        chk({tag, ".error"}, rsp_error, 1'b0);
        rsp_ready = oh(v.own);
        @(posedge clk);
        @(negedge clk);
        rsp_ready = '0;
        chk({tag, ".idle_busy"}, busy, 1'b0);
        chk({tag, ".idle_rsp_valid"}, rsp_valid, 2'b00);
    endtask

    vec_t tbl [6];

    initial begin
        int lat, runc;
        bit stable, seen, done;

        tbl[0] = '{2'b01, M_ABC, M_E,   2'd0, D_ABC};
        tbl[1] = '{2'b10, M_E,   M_A,   2'd1, D_A};
        tbl[2] = '{2'b11, M_E,   M_A,   2'd0, D_E};
        tbl[3] = '{2'b11, M_ABC, M_A,   2'd1, D_A};
        tbl[4] = '{2'b11, M_ABC, M_E,   2'd0, D_ABC};
        tbl[5] = '{2'b11, M_A,   M_E,   2'd1, D_E};

        reset = 1'b1;
        req_valid = '0; rsp_ready = '0; req_msg = '0;
        t_req_valid = '0; t_rsp_ready = '0; t_req_msg = '0;
        t_core_finish = 1'b0; t_core_digest = D_STUB; t_core_idx = 7'd93;
        repeat (3) @(negedge clk);

        chk("rst.rsp_valid", rsp_valid, 2'b00);
        chk("rst.rsp_digest", rsp_digest, 160'h0);
        chk("rst.rsp_error", rsp_error, 1'b0);
        chk("rst.core_on", core_on, 1'b0);
        chk("rst.core_reset", core_reset, 1'b1);
        chk("rst.core_msg", core_msg, 512'h0);
        chk("rst.owner", owner, 2'd0);
        chk("rst.busy", busy, 1'b0);
        req_valid = 2'b11;
        #1;
        chk("rst.req_ready", req_ready, 2'b00);
        chk("loop_idx", t_loop_idx, 7'd93);
        req_valid = '0;
        reset = 1'b0;
        @(negedge clk);

        for (int i = 0; i < 6; i++) begin
            run_vec(tbl[i], $sformatf("vec%0d", i));
        end

        // Response held off for 10 cycles while the other requester waits.
        req_valid = 2'b01;
        req_msg   = {M_A, M_ABC};
        #1;
        chk("hold.grant", req_ready, 2'b01);
        @(posedge clk);
        @(negedge clk);
        req_valid = 2'b10;
        wait_rsp(lat);
        chk("hold.rsp_valid", rsp_valid, 2'b01);
        rsp_ready = 2'b10;
        stable = 1;
        for (int c = 0; c < 10; c++) begin
            #1;
            if (rsp_valid !== 2'b01 || rsp_digest !== D_ABC || busy !== 1'b1 ||
                req_ready !== 2'b00) stable = 0;
            @(negedge clk);
        end
        chk("hold.stable", stable, 1'b1);
        rsp_ready = 2'b01;
        @(posedge clk);
        @(negedge clk);
        rsp_ready = '0;
        #1;
        chk("hold.b2b_grant", req_ready, 2'b10);
        run_vec('{2'b10, M_ABC, M_A, 2'd1, D_A}, "hold.next");

        // Reset in the middle of RUN.
        req_valid = 2'b01;
        req_msg   = {M_E, M_ABC};
        #1;
        chk("rstrun.grant", req_ready, 2'b01);
        @(posedge clk);
        @(negedge clk);
        req_valid = '0;
        repeat (10) @(negedge clk);
        chk("rstrun.core_on", core_on, 1'b1);
        reset = 1'b1;
        @(posedge clk);
        @(negedge clk);
        chk("rstrun.busy", busy, 1'b0);
        chk("rstrun.core_reset", core_reset, 1'b1);
        chk("rstrun.rsp_valid", rsp_valid, 2'b00);
        reset = 1'b0;
        seen = 0;
        for (int c = 0; c < 100; c++) begin
            @(negedge clk);
            if (|rsp_valid) seen = 1;
        end
        chk("rstrun.no_rsp", seen, 1'b0);
        run_vec('{2'b11, M_A, M_E, 2'd0, D_A}, "rstrun.after0");
        run_vec('{2'b10, M_A, M_E, 2'd1, D_E}, "rstrun.after1");

        // Timeout on the stub core that never finishes.
        t_req_valid = 2'b01;
        t_req_msg   = {512'h0, M_ABC};
        #1;
        chk("to.grant", t_req_ready, 2'b01);
        @(posedge clk);
        @(negedge clk);
        t_req_valid = '0;
        runc = 0; done = 0;
        for (int c = 0; c < 100; c++) begin
            if (|t_rsp_valid) begin done = 1; break; end
            if (t_core_on === 1'b1) runc++;
            @(negedge clk);
        end
        chk("to.run_cycles", runc, 16);
        chk("to.rsp_valid", t_rsp_valid, 2'b01);
        chk("to.error", t_rsp_error, 1'b1);
        chk("to.digest", t_rsp_digest, 160'h0);
        chk("to.busy", t_busy, 1'b1);
        t_rsp_ready = 2'b01;
        @(posedge clk);
        @(negedge clk);
        t_rsp_ready = '0;
        chk("to.idle", t_busy, 1'b0);

        // Finish arriving on the very cycle the timeout would fire.
        t_req_valid = 2'b10;
        t_req_msg   = {M_A, 512'h0};
        #1;
        chk("tofin.grant", t_req_ready, 2'b10);
        @(posedge clk);
        @(negedge clk);
        t_req_valid = '0;
        runc = 0; done = 0;
        for (int c = 0; c < 100; c++) begin
            if (|t_rsp_valid) begin done = 1; break; end
            if (t_core_on === 1'b1) begin
                runc++;
                if (runc == 16) t_core_finish = 1'b1;
            end
            @(negedge clk);
        end
        t_core_finish = 1'b0;
        chk("tofin.run_cycles", runc, 16);
        chk("tofin.rsp_valid", t_rsp_valid, 2'b10);
        chk("tofin.error", t_rsp_error, 1'b0);
        chk("tofin.digest", t_rsp_digest, D_STUB);
        t_rsp_ready = 2'b10;
        @(posedge clk);
        @(negedge clk);
        t_rsp_ready = '0;
        chk("tofin.idle", t_busy, 1'b0);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
        $finish;
    end

endmodule

// File: doc/sha1_arbiter.md
Name: sha1_arbiter

Overview:
Round-robin arbiter and sequencer that shares one sha1 compute core between NUM_REQ requesters, e.g. the Wishbone register front-end and a DMA/streaming master.
- Accepts one pre-padded 512-bit block per transaction.
- Resets and starts the core, waits for finish, and returns the 160-bit digest to the winning requester.
- Sits between the requester front-ends and the sha1 instance; owns the core's reset/on/message_in pins.

Parameters:
NUM_REQ, 2, number of requesters (2..4).
TIMEOUT_CYCLES, 255, max cycles in RUN before aborting with error.

Ports:
wb_clk_i  input  1  clock
reset  input  1  synchronous, active-high
req_valid  input  NUM_REQ  per-requester block-available
req_ready  output  NUM_REQ  one-hot grant/accept
req_msg  input  NUM_REQ*512  flattened blocks, requester i at [512*i+511:512*i]
rsp_valid  output  NUM_REQ  one-hot digest-available to owner
rsp_ready  input  NUM_REQ  owner consumes response
rsp_digest  output  160  digest of completed block (shared bus)
rsp_error  output  1  qualified by rsp_valid: 1 = timeout, digest invalid
core_reset  output  1  to sha1 reset
core_on  output  1  to sha1 on
core_msg  output  512  to sha1 message_in
core_digest  input  160  from sha1 digest
core_finish  input  1  from sha1 finish
core_idx  input  7  from sha1 idx (round counter)
busy  output  1  state != IDLE
owner  output  2  index of current/last grantee
loop_idx  output  7  core_idx passthrough for status register

Behaviour:
- Reset values: all req_ready/rsp_valid=0, rsp_digest=0, rsp_error=0, core_on=0, core_reset=1 (held during reset), core_msg=0, owner=0, RR pointer=0, state=IDLE.
- Reset mid-transaction: abort immediately; no response issued; core held in reset.
- States:
  - IDLE: req_ready combinational, one-hot, granted to the first req_valid bit at or after the RR pointer (wrapping), only in IDLE. Transfer on req_valid&req_ready. On transfer: latch req_msg slice into core_msg, set owner, RR pointer <= owner+1 mod NUM_REQ, go LOAD.
  - LOAD (1 cycle): core_reset=1, core_on=0; go RUN. Timeout counter cleared.
  - RUN: core_reset=0, core_on=1; counter increments each cycle.
    - core_finish=1: latch core_digest into rsp_digest, rsp_error=0, go RESP.
    - Counter == TIMEOUT_CYCLES without finish: rsp_error=1, rsp_digest=0, go RESP.
    - Finish on the timeout cycle: finish wins.
  - RESP: core_on=0; rsp_valid[owner]=1, held with stable rsp_digest/rsp_error until rsp_ready[owner]. On handshake go IDLE. rsp_ready of non-owners is ignored.
- Latency: request accept to rsp_valid = 2 + core compute cycles (core round count + finish latency).
- Back-to-back: earliest next grant is the cycle after the RESP handshake. req_valid deasserted before grant has no effect.
- Requester contract: req_valid must stay high until accepted. Requesters must not drop valid or change req_msg while waiting; the arbiter only samples on the transfer cycle.
- Fairness: with all requesters continuously valid, grants rotate 0,1,..,NUM_REQ-1,0.
- loop_idx = core_idx unregistered. busy registered from state.
- Core contract: the core restarts from the standard IV after reset. core_finish may be a pulse or a level; it is only sampled in RUN.

Decomposition:
- Shared package: state encoding (IDLE/LOAD/RUN/RESP), block width 512, digest width 160, idx width 7.
- Sub-module rr_arbiter (NUM_REQ, combinational grant from valid + pointer). Reusable by other shared engines.

Test Plan:
- Req0 sends padded "abc" (61626380 00..00 00000018) -> rsp_valid[0], rsp_digest = a9993e36 4706816a ba3e2571 7850c26c 9cd0d89d, rsp_error=0.
- Req0 and req1 valid same cycle, pointer=0 -> req0 granted first; req1 granted the cycle after req0's RESP handshake; owner 0 then 1.
- Both continuously valid for 4 transactions -> grant order 0,1,0,1; each digest routed to the correct requester.
- Stub core never finishes, TIMEOUT_CYCLES=16 -> rsp_error=1 and rsp_digest=0 exactly 16 cycles after RUN entry; arbiter returns to IDLE after the handshake.
- rsp_ready held low 10 cycles -> rsp_valid and rsp_digest stable throughout; no new grant; busy=1.
- reset asserted during RUN -> next cycle state IDLE, core_reset=1, no rsp_valid; a subsequent request completes correctly.
